// File: rtl/program_loader.sv
// Boot-time loader for the CHIP-8 memory write port: writes the hex fontset,
// then streams a ROM image in from PROG_BASE and raises done when complete.
module program_loader #(
    parameter logic [11:0] FONT_BASE = 12'h000,
    parameter logic [11:0] PROG_BASE = 12'h200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        reload,
    output logic        write,
    output logic [11:0] write_addr,
    output logic [7:0]  write_data,
    output logic        done,
    output logic        overflow,
    output logic [11:0] length
);

    // state | meaning
    // FONT  | writing fontset byte font_idx to FONT_BASE+font_idx
    // LOAD  | accepting image bytes, writing to PROG_BASE+length
    // DRAIN | memory full; accepting and discarding bytes until in_last
    // DONE  | image complete; CPU released; waits for reload
    typedef enum logic [1:0] {FONT, LOAD, DRAIN, DONE} state_t;

    // Byte 0 of the fontset sits in the most significant byte.
    localparam logic [639:0] FONTSET = {
        40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
        40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
        40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
        40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080
    };

    state_t      state;
    logic [6:0]  font_idx;
    logic [6:0]  font_rev;
    logic [9:0]  font_lsb;
    logic [7:0]  font_byte;
    logic [11:0] prog_addr;
    logic        accept;

    assign font_rev  = 7'd79 - font_idx;
    assign font_lsb  = {font_rev, 3'b000};
    assign font_byte = FONTSET[font_lsb +: 8];
    assign prog_addr = PROG_BASE + length;
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FONT;
            font_idx   <= 7'd0;
            in_ready   <= 1'b0;
            write      <= 1'b0;
            write_addr <= 12'd0;
            write_data <= 8'd0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            length     <= 12'd0;
        end else begin
            write <= 1'b0;
            case (state)
                FONT: begin
                    write      <= 1'b1;
                    write_addr <= FONT_BASE + {5'd0, font_idx};
                    write_data <= font_byte;
                    if (font_idx == 7'd79) begin
                        font_idx <= 7'd0;
                        state    <= LOAD;
                    end else begin
                        font_idx <= font_idx + 7'd1;
                    end
                end
                LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        write      <= 1'b1;
                        write_addr <= prog_addr;
                        write_data <= in_data;
                        length     <= length + 12'd1;
                        // ready drops on the same edge so no byte slips in after in_last
                        if (in_last) begin
                            in_ready <= 1'b0;
                            state    <= DONE;
                        end else if (prog_addr == 12'hFFF) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        overflow <= 1'b1;
                        if (in_last) begin
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    in_ready <= 1'b0;
                    done     <= 1'b1;
                    if (reload) begin
                        // first font byte goes out on the same edge that drops done
                        done       <= 1'b0;
                        length     <= 12'd0;
                        overflow   <= 1'b0;
                        write      <= 1'b1;
                        write_addr <= FONT_BASE;
                        write_data <= FONTSET[639 -: 8];
                        font_idx   <= 7'd1;
                        state      <= FONT;
                    end
                end
                default: state <= FONT;
            endcase
        end
    end

endmodule
